aes_stream_ctrl: RTL and testbench
==================================

Name: aes_stream_ctrl

Overview:
- Request sequencer directly upstream/downstream of the AES core wrapper (encrypt/decrypt selected by mode).
- Accepts {mode, key, block} requests on a valid/ready stream and buffers them in a small FIFO.
- Issues one ld pulse per block, waits for the core's done, captures text_out, and presents the result on a valid/ready output stream.
- Adds a done-timeout watchdog and a sticky error flag.

Parameters:
- DEPTH, 4: request FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 32: cycles after ld before an operation is abandoned; ≥16.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_mode  in  1  0 = encrypt, 1 = decrypt.
- in_key  in  128  key for this block.
- in_data  in  128  plaintext or ciphertext block.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  128  result block.
- out_mode  out  1  mode of the result block.
- core_ld  out  1  one-cycle load pulse to the core.
- core_mode  out  1  mode to the core; held stable from ld until done.
- core_key  out  128  key to the core; held stable from ld until done.
- core_text_in  out  128  block to the core; held stable from ld until done.
- core_text_out  in  128  core result; valid in the core_done cycle.
- core_done  in  1  one-cycle completion pulse from the core.
- iv_load  in  1  load the CBC chain register (CBC build only).
- iv  in  128  initial vector.
- busy  out  1  FIFO non-empty, or FSM not in IDLE, or out_valid set.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (rst==0 at a clk edge) clears the following:
  - FIFO pointers and count → 0; in_ready=0 during reset, 1 on the first cycle after.
  - FSM → IDLE; core_ld=0; core_mode/core_key/core_text_in=0.
  - out_valid=0; out_data=0; out_mode=0; err=0; watchdog count=0; chain=0.
- Reset mid-operation abandons the in-flight block and the FIFO contents. The core shares rst, so no stale done is expected.
- FIFO:
  - in_ready = !full; there is no same-cycle bypass when full, even if a pop occurs that cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if FIFO non-empty and out_valid==0 → LOAD. The head is popped into the core_* registers at this edge.
  - LOAD: core_ld=1 for exactly this one cycle; watchdog cleared → WAIT.
  - WAIT: watchdog increments each cycle.
    - core_done=1: capture core_text_out into out_data, out_mode=core_mode, set out_valid → IDLE.
    - Otherwise, watchdog==TIMEOUT_CYCLES-1: set err, discard the block, no output → IDLE.
    - If done and timeout occur in the same cycle, done wins.
  - A core_done outside WAIT is ignored.
- Output:
  - out_valid holds until out_ready. out_data and out_mode are stable while out_valid && !out_ready.
  - out_valid deasserts the cycle after the handshake.
- Latency: input accept → core_ld is 2 cycles minimum (1 cycle FIFO, 1 cycle IDLE→LOAD). core_done → out_valid is 1 cycle.
- Throughput: one block in flight at a time. The next ld cannot issue until the previous result is consumed.

Optional Feature:
- Macro: AES_STREAM_CBC_EN.
- Defined:
  - Encrypt: core_text_in = data ^ chain; chain ← core_text_out at done.
  - Decrypt: out_data = core_text_out ^ chain; chain ← original ciphertext at done.
  - iv_load loads chain from iv in any state; it takes effect for the next LOAD, not the block in flight.
  - On timeout, chain is unchanged.
- Undefined:
  - ECB only; iv_load and iv are ignored; no chain register is synthesised.

Decomposition:
- Package aes_stream_pkg holds:
  - typedef aes_blk_t (logic[127:0]);
  - typedef aes_req_t (struct: mode, key, data);
  - enum ctrl_state_t (IDLE, LOAD, WAIT);
  - localparam MODE_ENC=0, MODE_DEC=1.
- Sub-module aes_req_fifo: a parameterised DEPTH × aes_req_t synchronous FIFO with push/pop/full/empty.

Test Plan:
- FIPS-197 encrypt: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, mode 0 → out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_mode 0, exactly one core_ld pulse.
- Decrypt of the same ciphertext, mode 1 → 00112233445566778899aabbccddeeff; back-to-back enc/dec/enc requests emerge in order with correct modes.
- Backpressure: push 6 requests, DEPTH=4, out_ready=0 → in_ready low after 4 FIFO entries plus 1 in service; no ld issues while out_valid is held; draining returns all 6 in order.
- Timeout: core model never asserts done → err=1 after TIMEOUT_CYCLES, no out_valid, next request completes normally, err stays 1.
- Reset mid-WAIT with 3 queued → all outputs at reset values, busy=0, no result ever emitted.
- CBC build: iv 000102030405060708090a0b0c0d0e0f, key 2b7e151628aed2a6abf7158809cf4f3c, pt 6bc1bee22e409f96e93d7e117393172a → 7649abac8119b246cee98e9b12e9197d; decrypting that ciphertext with the same iv returns the pt.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// Shared types for the AES stream sequencer: block/request types, FSM states, mode codes.
package aes_stream_pkg;

    typedef logic [127:0] aes_blk_t;

    typedef struct packed {
        logic     mode;
        aes_blk_t key;
        aes_blk_t data;
    } aes_req_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } ctrl_state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int unsigned REQ_W = $bits(aes_req_t);

endpackage

// File: rtl/aes_stream_ctrl_fifo.sv
// Request FIFO: DEPTH entries of aes_req_t, synchronous active-low reset, combinational head.
module aes_req_fifo
    import aes_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [REQ_W-1:0] push_data,
    input  logic             pop,
    output logic [REQ_W-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [REQ_W-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Request sequencer around an AES core: FIFO in, one ld per block, done watchdog, result stream out.
// Optional CBC chaining is enabled by defining AES_STREAM_CBC_EN.
module aes_stream_ctrl
    import aes_stream_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_key,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_mode,
    output logic         core_ld,
    output logic         core_mode,
    output logic [127:0] core_key,
    output logic [127:0] core_text_in,
    input  logic [127:0] core_text_out,
    input  logic         core_done,
    input  logic         iv_load,
    input  logic [127:0] iv,
    output logic         busy,
    output logic         err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_t state, state_nxt;
    aes_req_t    push_req;
    aes_req_t    head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        done_ok;
    logic        timeout;
    logic [WD_W-1:0] wd_cnt;
    aes_blk_t    text_in_nxt;
    aes_blk_t    result;

    assign push_req = '{mode: in_mode, key: in_key, data: in_data};
    assign in_ready = rst && !fifo_full;
    assign busy     = !fifo_empty || (state != IDLE) || out_valid;

    aes_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid && in_ready),
        .push_data(push_req),
        .pop      (fifo_pop),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        core_ld   = 1'b0;
        done_ok   = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty && !out_valid) begin
                    fifo_pop  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                core_ld   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    done_ok   = 1'b1;
                    state_nxt = IDLE;
                end else if (wd_cnt == WD_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            core_mode    <= 1'b0;
            core_key     <= '0;
            core_text_in <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_mode     <= 1'b0;
            err          <= 1'b0;
            wd_cnt       <= '0;
        end else begin
            state <= state_nxt;
            if (fifo_pop) begin
                core_mode    <= head.mode;
                core_key     <= head.key;
                core_text_in <= text_in_nxt;
            end
            if (state == LOAD)      wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
            if (done_ok) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_mode  <= core_mode;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (timeout) err <= 1'b1;
        end
    end

`ifdef AES_STREAM_CBC_EN
    aes_blk_t chain;
    aes_blk_t blk_chain;
    logic     iv_seen;

    assign text_in_nxt = (head.mode == MODE_ENC) ? (head.data ^ chain) : head.data;
    assign result      = (core_mode == MODE_DEC) ? (core_text_out ^ blk_chain) : core_text_out;

    // blk_chain freezes the chain value for the block in flight; iv_seen stops its
    // completion from overwriting an IV loaded after that block was issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chain     <= '0;
            blk_chain <= '0;
            iv_seen   <= 1'b0;
        end else begin
            if (fifo_pop) blk_chain <= chain;
            if (iv_load)       iv_seen <= 1'b1;
            else if (fifo_pop) iv_seen <= 1'b0;
            if (iv_load) chain <= iv;
            else if (done_ok && !iv_seen)
                chain <= (core_mode == MODE_ENC) ? core_text_out : core_text_in;
        end
    end
`else
    logic unused_iv;

    assign text_in_nxt = head.data;
    assign result      = core_text_out;
    assign unused_iv   = &{1'b0, iv_load, iv};
`endif

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Self-checking bench for aes_stream_ctrl with a behavioural AES core stand-in and scoreboard.
module tb_aes_stream_ctrl;

    localparam int TO = 32;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] X2 = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] C2 = 128'h7649abac8119b246cee98e9b12e9197d;

    logic clk, rst, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic core_ld, core_mode, core_done, iv_load, busy, err;
    logic [127:0] in_key, in_data, out_data, core_key, core_text_in, core_text_out, iv;

    aes_stream_ctrl #(.DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_key(in_key), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_mode(out_mode), .core_ld(core_ld), .core_mode(core_mode),
        .core_key(core_key), .core_text_in(core_text_in), .core_text_out(core_text_out),
        .core_done(core_done), .iv_load(iv_load), .iv(iv), .busy(busy), .err(err)
    );

    typedef struct { logic mode; logic [127:0] key; logic [127:0] data; } req_t;
    typedef struct { logic mode; logic [127:0] data; } res_t;

    req_t send_q[$];
    res_t exp_q[$];
    int   n_vec = 0, n_err = 0;
    int   accepted = 0, ld_count = 0;
    bit   hold_chk = 0, hang = 0, core_abort = 0, spur_req = 0, iv_ld_req = 0;
    int   fixed_lat = 0;
    logic [127:0] hold_data, tb_chain = '0;
    logic hold_mode;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Known AES-128 vectors, otherwise an invertible toy cipher (rotate/xor).
    function automatic logic [127:0] core_fn(input logic m, input logic [127:0] k, input logic [127:0] x);
        logic [127:0] y;
        if (!m && k == K1 && x == P1) return C1;
        if (m && k == K1 && x == C1) return P1;
        if (!m && k == K2 && x == X2) return C2;
        if (m && k == K2 && x == C2) return X2;
        if (!m) return {x[126:0], x[127]} ^ k;
        y = x ^ k;
        return {y[0], y[127:1]};
    endfunction

    task automatic queue_req(input logic m, input logic [127:0] k, input logic [127:0] d,
                             input bit use_exp, input logic [127:0] e);
        req_t r;
        res_t x;
        logic [127:0] v;
`ifdef AES_STREAM_CBC_EN
        if (!m) begin v = core_fn(1'b0, k, d ^ tb_chain); tb_chain = v; end
        else begin v = core_fn(1'b1, k, d) ^ tb_chain; tb_chain = d; end
`else
        v = core_fn(m, k, d);
`endif
        if (use_exp) v = e;
        r.mode = m; r.key = k; r.data = d;
        x.mode = m; x.data = v;
        send_q.push_back(r);
        exp_q.push_back(x);
    endtask

    task automatic queue_rand();
        queue_req(1'($urandom_range(1)), rnd128(), rnd128(), 1'b0, '0);
    endtask

    task automatic cycle(input int unsigned vpct, input int unsigned rpct);
        res_t x;
        @(negedge clk);
        if (hold_chk) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, hold_data);
            chk("hold_mode", out_mode, hold_mode);
        end
        in_valid = (send_q.size() > 0) && ($urandom_range(99) < vpct);
        if (send_q.size() > 0) begin
            in_mode = send_q[0].mode;
            in_key  = send_q[0].key;
            in_data = send_q[0].data;
        end
        out_ready = ($urandom_range(99) < rpct);
`ifdef AES_STREAM_CBC_EN
        iv_load = iv_ld_req;
`else
        iv_load = 1'($urandom_range(1));
        iv      = rnd128();
`endif
        if (in_valid && in_ready) begin
            accepted++;
            void'(send_q.pop_front());
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("out_unexpected", out_valid, 0);
            else begin
                x = exp_q.pop_front();
                chk("out_data", out_data, x.data);
                chk("out_mode", out_mode, x.mode);
            end
        end
        hold_chk  = out_valid && !out_ready;
        hold_data = out_data;
        hold_mode = out_mode;
    endtask

    task automatic drain(input int unsigned vpct, input int unsigned rpct);
        int unsigned n = 0;
        while ((send_q.size() > 0 || exp_q.size() > 0 || busy) && n < 3000) begin
            cycle(vpct, rpct);
            n++;
        end
        chk("drain_in_budget", n < 3000, 1);
    endtask

    // Core stand-in: latency 1..8 (or fixed_lat), checks operands held from ld until done.
    initial begin : core_model
        bit pending = 0;
        bit ld_prev = 0;
        int cnt = 0;
        logic lat_mode = 0;
        logic [127:0] lat_key = '0, lat_text = '0;
        core_done = 0;
        core_text_out = '0;
        forever begin
            @(negedge clk);
            core_done = 0;
            if (!rst || core_abort) begin
                pending = 0;
                core_abort = 0;
            end
            if (pending) begin
                chk("core_mode_held", core_mode, lat_mode);
                chk("core_key_held", core_key, lat_key);
                chk("core_text_held", core_text_in, lat_text);
                if (!hang) begin
                    if (cnt <= 1) begin
                        core_done = 1;
                        core_text_out = core_fn(lat_mode, lat_key, lat_text);
                        pending = 0;
                    end else cnt--;
                end
            end else if (spur_req) begin
                core_done = 1;
                core_text_out = rnd128();
                spur_req = 0;
            end
            if (core_ld) begin
                chk("ld_single_cycle", ld_prev, 0);
                chk("ld_while_out_valid", out_valid, 0);
                ld_count++;
                lat_mode = core_mode; lat_key = core_key; lat_text = core_text_in;
                pending = 1;
                cnt = (fixed_lat != 0) ? fixed_lat : $urandom_range(8, 1);
            end
            ld_prev = core_ld;
        end
    end

    initial begin : stimulus
        int ld0, acc0, n;
        logic [127:0] saved_chain;
        rst = 0; in_valid = 0; in_mode = 0; in_key = '0; in_data = '0;
        out_ready = 0; iv_load = 0; iv = '0;

        // Reset state
        repeat (3) cycle(0, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_core_ld", core_ld, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        rst = 1;
        cycle(0, 0);
        chk("in_ready_after_rst", in_ready, 1);

`ifdef AES_STREAM_CBC_EN
        iv = K1; iv_ld_req = 1; cycle(0, 0); iv_ld_req = 0; tb_chain = K1;
        queue_req(1'b0, K2, P2, 1'b1, C2);
        drain(100, 100);
        iv = K1; iv_ld_req = 1; cycle(0, 0); iv_ld_req = 0; tb_chain = K1;
        queue_req(1'b1, K2, C2, 1'b1, P2);
        drain(100, 100);
`else
        ld0 = ld_count;
        queue_req(1'b0, K1, P1, 1'b1, C1);
        drain(100, 100);
        chk("fips_one_ld", ld_count - ld0, 1);
        queue_req(1'b1, K1, C1, 1'b1, P1);
        queue_req(1'b0, K1, P1, 1'b1, C1);
        queue_req(1'b1, K1, C1, 1'b1, P1);
        drain(100, 100);
`endif

        // Done and timeout in the same cycle: done wins
        fixed_lat = TO;
        queue_rand();
        drain(100, 100);
        fixed_lat = 0;
        chk("done_wins_err", err, 0);

        // Spurious done while idle is ignored
        spur_req = 1;
        repeat (4) cycle(0, 100);
        chk("spur_no_out", out_valid, 0);
        chk("spur_idle", busy, 0);

        // Randomised traffic with backpressure
        repeat (40) queue_rand();
        drain(60, 50);

        // Backpressure: 4 in FIFO + 1 in service
        ld0 = ld_count; acc0 = accepted;
        repeat (6) queue_rand();
        repeat (30) cycle(100, 0);
        chk("bp_accepted", accepted - acc0, 5);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_single_ld", ld_count - ld0, 1);
        chk("bp_out_valid", out_valid, 1);
        drain(100, 100);
        chk("bp_total_ld", ld_count - ld0, 6);

        // Timeout
        hang = 1;
        saved_chain = tb_chain;
        queue_rand();
        n = 0;
        while (!core_ld && n < 50) begin cycle(100, 100); n++; end
        chk("to_ld_seen", core_ld, 1);
        void'(exp_q.pop_back());
        tb_chain = saved_chain;
        repeat (TO) cycle(0, 100);
        chk("to_err_not_early", err, 0);
        chk("to_busy_waiting", busy, 1);
        cycle(0, 100);
        chk("to_err_set", err, 1);
        chk("to_no_out", out_valid, 0);
        chk("to_idle", busy, 0);
        core_abort = 1; hang = 0;
        repeat (3) cycle(0, 100);
        queue_rand();
        drain(100, 100);
        chk("to_err_sticky", err, 1);

        // Reset mid-WAIT with 3 queued
        hang = 1;
        repeat (4) queue_rand();
        repeat (8) cycle(100, 100);
        chk("mid_busy", busy, 1);
        send_q.delete();
        hold_chk = 0;
        rst = 0;
        cycle(0, 0);
        cycle(0, 0);
        chk("mid_in_ready", in_ready, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_out_data", out_data, 0);
        chk("mid_out_mode", out_mode, 0);
        chk("mid_core_ld", core_ld, 0);
        chk("mid_core_mode", core_mode, 0);
        chk("mid_core_key", core_key, 0);
        chk("mid_core_text", core_text_in, 0);
        chk("mid_err", err, 0);
        chk("mid_busy_rst", busy, 0);
        exp_q.delete();
        tb_chain = '0;
        hang = 0;
        rst = 1;
        ld0 = ld_count;
        repeat (20) begin
            cycle(0, 100);
            chk("mid_no_result", out_valid, 0);
        end
        chk("mid_no_ld", ld_count - ld0, 0);
        chk("mid_in_ready_after", in_ready, 1);

        // Normal operation resumes after reset
        repeat (10) queue_rand();
        drain(80, 70);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
